// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Covers the ALU op codes, the RV64 major opcodes it decodes, and the FSM/operand-select enums.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
  typedef enum logic [1:0] {B_RS2, B_IMM_I, B_IMM_S} b_sel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV64 decoder: maps an instruction to an ALU op code, operand-b source and
// sign-extended immediate, and flags BEQ and unsupported encodings.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [3:0]      alu_op,
  output b_sel_e          b_sel,
  output logic [XLEN-1:0] imm,
  output logic            is_beq,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic            w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  // The rs1 field is not needed: the register value arrives already read.
  assign w_unused = ^instr[19:15];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_op  = ALU_ADD;
    b_sel   = B_RS2;
    is_beq  = 1'b0;
    illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op = ALU_SUB;
          {7'b0000000, 3'b111}: alu_op = ALU_AND;
          {7'b0000000, 3'b110}: alu_op = ALU_OR;
          default:              illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        b_sel = B_IMM_I;
        case (w_funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        b_sel   = B_IMM_I;
        illegal = (w_funct3 != 3'b011);
      end
      OPC_STORE: begin
        b_sel   = B_IMM_S;
        illegal = (w_funct3 != 3'b011);
      end
      OPC_BRANCH: begin
        alu_op  = ALU_SUB;
        is_beq  = (w_funct3 == 3'b000);
        illegal = (w_funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm = (b_sel == B_IMM_S) ? w_imm_s : w_imm_i;

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one instruction plus operands, drives the external combinational ALU for ALU_LAT
// cycles, then returns the captured result and flags on a valid/ready channel.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_branch_taken,
  output logic            out_illegal
);

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_is_beq;
  logic [3:0]      w_dec_op;
  b_sel_e          w_dec_b_sel;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_is_beq;
  logic            w_dec_illegal;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .alu_op  (w_dec_op),
    .b_sel   (w_dec_b_sel),
    .imm     (w_dec_imm),
    .is_beq  (w_dec_is_beq),
    .illegal (w_dec_illegal)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  // NOTE: state and every datapath register use non-blocking assignments so all of them
  // update together at the edge; all of them reset so no output is ever X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_is_beq         <= 1'b0;
      alu_a            <= '0;
      alu_b            <= '0;
      alu_op           <= '0;
      out_result       <= '0;
      out_zero         <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_dec_illegal) begin
              out_illegal      <= 1'b1;
              out_result       <= '0;
              out_zero         <= 1'b0;
              out_branch_taken <= 1'b0;
              r_state          <= ST_DONE;
            end else begin
              alu_a    <= rs1_val;
              alu_b    <= (w_dec_b_sel == B_RS2) ? rs2_val : w_dec_imm;
              alu_op   <= w_dec_op;
              r_is_beq <= w_dec_is_beq;
              r_cnt    <= 4'(ALU_LAT - 1);
              r_state  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            out_result       <= alu_result;
            out_zero         <= alu_zero;
            out_branch_taken <= r_is_beq && alu_zero;
            out_illegal      <= 1'b0;
            r_state          <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=1 and ALU_LAT=3), each with a behavioural ALU model
// doing true subtraction, checked against hand-computed results, latencies and reset behaviour.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] rs1, rs2;

  logic        d1_in_valid, d1_in_ready, d1_alu_zero, d1_out_valid, d1_out_zero, d1_out_bt, d1_out_ill;
  logic [63:0] d1_alu_a, d1_alu_b, d1_alu_result, d1_out_result;
  logic [3:0]  d1_alu_op;
  logic        d3_in_valid, d3_in_ready, d3_alu_zero, d3_out_valid, d3_out_zero, d3_out_bt, d3_out_ill;
  logic [63:0] d3_alu_a, d3_alu_b, d3_alu_result, d3_out_result;
  logic [3:0]  d3_alu_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    logic [63:0] x, y;
    x = op[3] ? ~a : a;
    y = op[2] ? (~b + 64'd1) : b;
    case (op[1:0])
      2'b00:   return x & y;
      2'b01:   return x | y;
      default: return x + y;
    endcase
  endfunction

  assign d1_alu_result = alu_model(d1_alu_a, d1_alu_b, d1_alu_op);
  assign d1_alu_zero   = (d1_alu_result == 64'd0);
  assign d3_alu_result = alu_model(d3_alu_a, d3_alu_b, d3_alu_op);
  assign d3_alu_zero   = (d3_alu_result == 64'd0);

  alu_op_sequencer #(.XLEN(64), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .instr(instr),
    .rs1_val(rs1), .rs2_val(rs2), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
    .alu_result(d1_alu_result), .alu_zero(d1_alu_zero), .out_valid(d1_out_valid),
    .out_ready(out_ready), .out_result(d1_out_result), .out_zero(d1_out_zero),
    .out_branch_taken(d1_out_bt), .out_illegal(d1_out_ill)
  );

  alu_op_sequencer #(.XLEN(64), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready), .instr(instr),
    .rs1_val(rs1), .rs2_val(rs2), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_result(d3_alu_result), .alu_zero(d3_alu_zero), .out_valid(d3_out_valid),
    .out_ready(out_ready), .out_result(d3_out_result), .out_zero(d3_out_zero),
    .out_branch_taken(d3_out_bt), .out_illegal(d3_out_ill)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm, 5'd2, f3, 5'd1, opc};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd3, 5'd2, f3, imm[4:0], 7'b0100011};
  endfunction

  // Presents one instruction, returns the number of cycles from the accept cycle until
  // out_valid is seen (bounded at 20).
  task automatic send(input bit sel3, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", sel3 ? d3_in_ready : d1_in_ready, 1);
    instr = ins; rs1 = a; rs2 = b;
    if (sel3) d3_in_valid = 1'b1; else d1_in_valid = 1'b1;
    @(posedge clk);
    #1 d1_in_valid = 1'b0; d3_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel3 ? d3_out_valid : d1_out_valid) && lat < 20);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; out_ready = 1'b1; d1_in_valid = 1'b0; d3_in_valid = 1'b0;
    instr = '0; rs1 = '0; rs2 = '0;

    #12;
    check("rst_alu_a", d1_alu_a, 0);
    check("rst_alu_op", d1_alu_op, 0);
    check("rst_out_result", d1_out_result, 0);
    check("rst_out_valid", d1_out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_in_ready", d1_in_ready, 1);

    send(0, r_type(7'b0000000, 3'b000), 64'd5, 64'd7, lat);
    check("add_lat", lat, 2);
    check("add_op", d1_alu_op, 4'b0010);
    check("add_result", d1_out_result, 64'd12);
    check("add_zero", d1_out_zero, 0);

    send(0, {7'd0, 5'd3, 5'd2, 3'b000, 5'd0, 7'b1100011}, 64'h1234, 64'h1234, lat);
    check("beq_eq_op", d1_alu_op, 4'b0110);
    check("beq_eq_result", d1_out_result, 0);
    check("beq_eq_zero", d1_out_zero, 1);
    check("beq_eq_taken", d1_out_bt, 1);

    send(0, {7'd0, 5'd3, 5'd2, 3'b000, 5'd0, 7'b1100011}, 64'h1234, 64'h1235, lat);
    check("beq_ne_result", d1_out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("beq_ne_taken", d1_out_bt, 0);

    send(0, i_type(12'hFFF, 3'b000, 7'b0010011), 64'd1, 64'd99, lat);
    check("addi_alu_b", d1_alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_result", d1_out_result, 0);
    check("addi_zero", d1_out_zero, 1);
    check("addi_taken", d1_out_bt, 0);

    send(0, s_type(12'hFF8, 3'b011), 64'h100, 64'h5555, lat);
    check("sd_result", d1_out_result, 64'hF8);

    send(0, 32'h0000_007F, 64'h77, 64'h88, lat);
    check("ill_lat", lat, 1);
    check("ill_flag", d1_out_ill, 1);
    check("ill_result", d1_out_result, 0);
    check("ill_alu_op_kept", d1_alu_op, 4'b0010);
    check("ill_alu_b_kept", d1_alu_b, 64'hFFFF_FFFF_FFFF_FFF8);

    send(0, i_type(12'h0F0, 3'b111, 7'b0010011), 64'hABCD, 64'd0, lat);
    check("andi_result", d1_out_result, 64'hC0);
    check("andi_ill_cleared", d1_out_ill, 0);

    // Long-latency instance with back-pressure on the response channel.
    out_ready = 1'b0;
    send(1, r_type(7'b0000000, 3'b110), 64'hF0, 64'h0F, lat);
    check("lat3_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", d3_out_valid, 1);
      check("hold_result", d3_out_result, 64'hFF);
      check("hold_in_ready", d3_in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", d3_in_ready, 1);
    check("release_valid", d3_out_valid, 0);

    // Reset asserted while the long-latency instance is executing.
    @(negedge clk);
    instr = r_type(7'b0000000, 3'b110); rs1 = 64'hF0; rs2 = 64'h0F; d3_in_valid = 1'b1;
    @(posedge clk);
    #1 d3_in_valid = 1'b0;
    @(negedge clk);
    check("exec_alu_a", d3_alu_a, 64'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_alu_a", d3_alu_a, 0);
    check("abort_alu_op", d3_alu_op, 0);
    check("abort_out_result", d3_out_result, 0);
    check("abort_out_valid", d3_out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("abort_in_ready", d3_in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d3_out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator-side companion to the 64-bit ALU.
- Accepts one RV64 instruction plus register operands per handshake and decodes it to the 4-bit ALU operation code.
- Drives operands and code into the combinational ALU, waits a fixed number of cycles, then captures Result/Zero.
- Returns result, zero, branch-taken and illegal flags on a valid/ready output channel. Sits between the decode stage and the ALU.

Parameters:
- XLEN, 64, datapath width for operands and result.
- ALU_LAT, 1, cycles spent in EXEC before capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  sequencer can accept
- instr  in  32  RV64 instruction word
- rs1_val  in  XLEN  source register 1 value
- rs2_val  in  XLEN  source register 2 value
- alu_a  out  XLEN  ALU operand a (registered)
- alu_b  out  XLEN  ALU operand b (registered)
- alu_op  out  4  ALU operation code (registered): bit3 a-invert, bit2 b-negate, [1:0] 00 AND / 01 OR / 10 ADD
- alu_result  in  XLEN  ALU Result
- alu_zero  in  1  ALU Zero
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- out_result  out  XLEN  captured result
- out_zero  out  1  captured zero flag
- out_branch_taken  out  1  BEQ and zero
- out_illegal  out  1  unsupported instruction

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter 0.
- Reset values: all registered outputs 0, including alu_a/alu_b/alu_op, out_* and out_valid. in_ready=1 once rst_n deasserts.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- FSM states: IDLE, EXEC, DONE.
- IDLE: on in_valid && in_ready, decode instr.
  - Legal: register alu_a/alu_b/alu_op, load counter with ALU_LAT-1, go EXEC.
  - Illegal: out_illegal=1, out_result=0, out_zero=0, out_branch_taken=0, alu_* unchanged, go DONE.
- EXEC: if counter==0, capture alu_result into out_result and alu_zero into out_zero. Set out_branch_taken = is_beq && alu_zero, out_illegal=0, go DONE. Otherwise decrement the counter.
- DONE: hold all out_* stable while out_ready=0. On out_ready, go IDLE. out_* keep their values until the next capture.
- Latency, legal instruction: accepted at edge N, out_valid high after edge N+1+ALU_LAT.
- Latency, illegal instruction: out_valid high after edge N+1.
- No overlap: the next accept is earliest the cycle after the DONE handshake.
- Decode table (opcode/funct3/funct7 -> alu_op, b source):
  - 0110011/000/0000000 ADD -> 0010, rs2
  - 0110011/000/0100000 SUB -> 0110, rs2
  - 0110011/111/0000000 AND -> 0000, rs2
  - 0110011/110/0000000 OR -> 0001, rs2
  - 0010011/000 ADDI -> 0010, immI
  - 0010011/111 ANDI -> 0000, immI
  - 0010011/110 ORI -> 0001, immI
  - 0000011/011 LD -> 0010, immI
  - 0100011/011 SD -> 0010, immS
  - 1100011/000 BEQ -> 0110, rs2
  - Anything else: illegal.
- Operand a is always rs1_val.
- immI = sign-extend(instr[31:20]) to XLEN.
- immS = sign-extend({instr[31:25], instr[11:7]}) to XLEN.
- Arithmetic is modulo 2^XLEN.
- in_valid while not ready: ignored; the sender holds.
- Reset mid-EXEC or mid-DONE: transaction dropped, no out_valid pulse.

Decomposition:
- Package alu_seq_pkg holds:
  - ALU op constants: AND=0000, OR=0001, ADD=0010, SUB=0110.
  - Opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH.
  - State enum IDLE/EXEC/DONE.
  - Operand-select enum RS2/IMM_I/IMM_S.
- One combinational sub-module alu_op_decode.
  - Input: instr.
  - Outputs: alu_op, b_sel, imm, is_beq, illegal.
  - The top keeps the FSM, counter and registers.

Test Plan (bench uses a behavioural ALU model with true subtraction; ALU_LAT=1 unless noted):
- ADD x, rs1=5, rs2=7 -> alu_op=0010, out_result=12, out_zero=0, out_valid 2 cycles after accept.
- BEQ, rs1=rs2=0x1234 -> alu_op=0110, out_result=0, out_zero=1, out_branch_taken=1. Repeat with rs2=0x1235 -> out_branch_taken=0.
- ADDI imm=0xFFF, rs1=1 -> alu_b=0xFFFF_FFFF_FFFF_FFFF, out_result=0, out_zero=1. SD with immS=-8, rs1=0x100 -> out_result=0xF8.
- instr=0x0000007F -> out_valid 1 cycle after accept, out_illegal=1, out_result=0, alu_op unchanged.
- ALU_LAT=3, OR rs1=0xF0, rs2=0x0F, out_ready=0 for 5 cycles -> out_valid at accept+4, out_result=0xFF held stable, in_ready=0 throughout; accept completes on out_ready=1, in_ready=1 next cycle.
- rst_n pulsed low during EXEC -> all outputs 0 immediately, in_ready=1 after release, no out_valid for the aborted instruction.
